barrel_fetch_unit: RTL
======================

Name: barrel_fetch_unit

Overview:
- Fetch stage of the barrel-threaded RV32 core, directly upstream of the fetch/decode pipeline register.
- Holds one PC per hardware thread and picks the issuing thread each cycle, round-robin over enabled threads.
- Drives the instruction-memory address and presents pc, pc+4, instruction, tid and valid to the F/D register in the same cycle.
- Accepts per-thread PC redirects from the execute stage.

Parameters:
- ADDRESS_WIDTH, 32, PC and instruction-address width.
- DATA_WIDTH, 32, instruction width.
- BITS_THREADS, 3, thread-id width; NUM_THREADS = 2**BITS_THREADS.
- RESET_PC, 32'h0000_0000, reset PC of thread 0.
- THREAD_PC_STRIDE, 32'h0000_0400, reset-PC spacing between threads.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall_f_i  in  1  1 = hold thread pointer and all PCs (redirect writes still apply).
- thread_en_i  in  NUM_THREADS  per-thread enable mask.
- redirect_valid_i  in  1  execute-stage PC redirect (branch or jump).
- redirect_tid_i  in  BITS_THREADS  thread being redirected.
- redirect_pc_i  in  ADDRESS_WIDTH  redirect target.
- imem_addr_o  out  ADDRESS_WIDTH  instruction-memory address (combinational read).
- imem_rdata_i  in  DATA_WIDTH  instruction-memory read data.
- pc_f_o  out  ADDRESS_WIDTH  PC of the fetched instruction.
- pc_plus4_f_o  out  ADDRESS_WIDTH  pc_f_o + 4.
- instr_f_o  out  DATA_WIDTH  fetched instruction.
- tid_f_o  out  BITS_THREADS  issuing thread.
- valid_f_o  out  1  fetched instruction is live.

Behaviour:
- State:
  - tid_q: BITS_THREADS register.
  - pc_q[NUM_THREADS]: ADDRESS_WIDTH registers.
- Reset (async on rst_n low, held while low):
  - tid_q = 0.
  - pc_q[i] = RESET_PC + i*THREAD_PC_STRIDE.
  - Resulting outputs: pc_f_o = RESET_PC, pc_plus4_f_o = RESET_PC+4, tid_f_o = 0, valid_f_o = thread_en_i[0].
- Combinational outputs (zero latency to the F/D register):
  - pc_f_o = imem_addr_o = pc_q[tid_q].
  - pc_plus4_f_o = pc_q[tid_q] + 4, modulo 2^ADDRESS_WIDTH, so 0xFFFF_FFFC -> 0x0.
  - instr_f_o = imem_rdata_i.
  - tid_f_o = tid_q.
- valid_f_o = thread_en_i[tid_q] AND NOT (redirect_valid_i AND redirect_tid_i == tid_q). A same-cycle redirect of the issuing thread kills the wrong-path fetch.
- Rising edge with stall_f_i = 0:
  - If valid_f_o, pc_q[tid_q] <= pc_q[tid_q] + 4.
  - tid_q <= first enabled thread found searching tid_q+1, tid_q+2, ..., tid_q+NUM_THREADS (mod NUM_THREADS). The search includes tid_q itself last.
  - If thread_en_i == 0, tid_q holds.
- Rising edge with stall_f_i = 1: tid_q and all PC increments hold.
- Redirect, on every edge including stalled ones:
  - pc_q[redirect_tid_i] <= {redirect_pc_i[ADDRESS_WIDTH-1:2], 2'b00}; low two bits are forced to zero.
  - If the redirect targets tid_q in the same cycle as its increment, the redirect wins.
- A thread disabled while tid_q points at it:
  - valid_f_o = 0 and its PC does not advance.
  - The pointer moves on at the next non-stalled edge.
- A disabled thread's PC is retained and accepts redirects; it resumes from that PC when re-enabled.
- No multi-cycle state machine. The round-robin pointer is the only sequencing state.

Decomposition:
- Shared package core_pkg:
  - NUM_THREADS.
  - RESET_PC and THREAD_PC_STRIDE defaults.
  - INSTR_NOP = 32'h0000_0013, used downstream for killed slots.
- One sub-module, rr_thread_picker: purely combinational. Takes (current tid, enable mask) and returns (next tid, any_enabled).

Test Plan:
1. Reset, thread_en=8'hFF, no stall, no redirect -> tid_f_o 0,1,...,7,0,1; pc_f_o 0x0, 0x400, ..., 0x1C00, then 0x4, 0x404; valid_f_o=1 every cycle.
2. thread_en=8'b0000_0101 -> tid 0,2,0,2; pc 0x0, 0x800, 0x4, 0x804; threads 1 and 3–7 keep their reset PCs.
3. Redirect tid=3 to 0x2003 while tid_q=1 -> next visit of thread 3 shows pc_f_o=0x2000. Redirect tid=2 to 0x3000 while tid_q=2 -> valid_f_o=0 that cycle, next thread-2 fetch at pc 0x3000.
4. stall_f_i=1 for 3 cycles at tid=4, pc=0x1004 -> tid/pc/valid frozen. A redirect of tid 6 to 0x500 during the stall is applied; thread 6 fetches 0x500 after the stall.
5. thread_en=0 -> valid_f_o=0 and tid_q holds. Then thread_en=8'h20 -> tid_f_o=5 after one edge; thread 5 fetches pc 0x1400 then 0x1404.
6. pc_q[0] redirected to 0xFFFF_FFFC -> pc_plus4_f_o=0x0, next thread-0 fetch at 0x0. rst_n pulsed low mid-cycle -> outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/core_pkg.sv
// Shared constants for the barrel-threaded RV32 core: thread count,
// per-thread reset PCs and the canonical NOP used for killed slots.
package core_pkg;

  localparam int          NUM_THREADS          = 8;
  localparam int          BITS_THREADS_DEF     = $clog2(NUM_THREADS);
  localparam logic [31:0] RESET_PC_DEF         = 32'h0000_0000;
  localparam logic [31:0] THREAD_PC_STRIDE_DEF = 32'h0000_0400;
  localparam logic [31:0] INSTR_NOP            = 32'h0000_0013;

endpackage

// File: rtl/rr_thread_picker.sv
// Combinational round-robin picker: finds the first enabled thread after
// cur_tid, wrapping around and considering cur_tid itself last.
module rr_thread_picker #(
  parameter int BITS_THREADS = 3
) (
  input  logic [BITS_THREADS-1:0]      cur_tid,
  input  logic [(2**BITS_THREADS)-1:0] thread_en,
  output logic [BITS_THREADS-1:0]      next_tid,
  output logic                         any_enabled
);

  localparam int NUM_THR = 2**BITS_THREADS;

  logic [BITS_THREADS-1:0] cand;
  logic                    found;

  always_comb begin
    // NOTE: every output gets a default before the loop; otherwise a path
    // that never assigns it would infer a latch.
    next_tid    = cur_tid;
    any_enabled = |thread_en;
    cand        = cur_tid;
    found       = 1'b0;
    // Offset NUM_THR truncates to zero, so the current thread is tried last.
    for (int k = 1; k <= NUM_THR; k++) begin
      cand = cur_tid + BITS_THREADS'(k);
      if (!found && thread_en[cand]) begin
        next_tid = cand;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/barrel_fetch_unit.sv
// Fetch stage of the barrel-threaded core: one PC per thread, round-robin
// issue over enabled threads, zero-latency outputs to the F/D register.
module barrel_fetch_unit
  import core_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH    = 32,
  parameter int                     DATA_WIDTH       = 32,
  parameter int                     BITS_THREADS     = BITS_THREADS_DEF,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC         = RESET_PC_DEF,
  parameter logic [ADDRESS_WIDTH-1:0] THREAD_PC_STRIDE = THREAD_PC_STRIDE_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall_f_i,
  input  logic [(2**BITS_THREADS)-1:0] thread_en_i,
  input  logic                         redirect_valid_i,
  input  logic [BITS_THREADS-1:0]      redirect_tid_i,
  input  logic [ADDRESS_WIDTH-1:0]     redirect_pc_i,
  output logic [ADDRESS_WIDTH-1:0]     imem_addr_o,
  input  logic [DATA_WIDTH-1:0]        imem_rdata_i,
  output logic [ADDRESS_WIDTH-1:0]     pc_f_o,
  output logic [ADDRESS_WIDTH-1:0]     pc_plus4_f_o,
  output logic [DATA_WIDTH-1:0]        instr_f_o,
  output logic [BITS_THREADS-1:0]      tid_f_o,
  output logic                         valid_f_o
);

  localparam int NUM_THR = 2**BITS_THREADS;

  logic [BITS_THREADS-1:0]  tid_q;
  logic [ADDRESS_WIDTH-1:0] pc_q [NUM_THR];
  logic [BITS_THREADS-1:0]  next_tid;
  logic                     any_enabled;
  logic [ADDRESS_WIDTH-1:0] cur_pc;
  logic [ADDRESS_WIDTH-1:0] cur_pc_plus4;
  logic                     redirect_self;

  rr_thread_picker #(
    .BITS_THREADS (BITS_THREADS)
  ) u_picker (
    .cur_tid     (tid_q),
    .thread_en   (thread_en_i),
    .next_tid    (next_tid),
    .any_enabled (any_enabled)
  );

  assign cur_pc        = pc_q[tid_q];
  assign cur_pc_plus4  = cur_pc + ADDRESS_WIDTH'(4);
  // A redirect of the issuing thread means this fetch is on the wrong path.
  assign redirect_self = redirect_valid_i && (redirect_tid_i == tid_q);

  assign imem_addr_o   = cur_pc;
  assign pc_f_o        = cur_pc;
  assign pc_plus4_f_o  = cur_pc_plus4;
  assign instr_f_o     = imem_rdata_i;
  assign tid_f_o       = tid_q;
  assign valid_f_o     = thread_en_i[tid_q] && !redirect_self;

  // NOTE: the PC file is architectural state (each thread boots from its own
  // vector), so it is reset like any register rather than left as a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tid_q <= '0;
      for (int i = 0; i < NUM_THR; i++) begin
        pc_q[i] <= RESET_PC + ADDRESS_WIDTH'(i) * THREAD_PC_STRIDE;
      end
    end else begin
      // NOTE: non-blocking assignments let the redirect write below override
      // the increment to the same entry (last NBA wins) without ordering hazards.
      if (!stall_f_i && valid_f_o) begin
        pc_q[tid_q] <= cur_pc_plus4;
      end
      if (redirect_valid_i) begin
        pc_q[redirect_tid_i] <= {redirect_pc_i[ADDRESS_WIDTH-1:2], 2'b00};
      end
      if (!stall_f_i && any_enabled) begin
        tid_q <= next_tid;
      end
    end
  end

endmodule
